imem_line_responder: RTL and testbench

IMEM_LINE_RESPONDER -- requirements
Module: imem_line_responder

---
 rtl/imem_line_responder.sv | 127 ++++++++++++
 tb/tb_imem_line_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_line_responder.sv
// Instruction-cache line refill responder: splits one line request into
// BEATS sequential word reads and returns the assembled line with a one-cycle ack.
module imem_line_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imem_sel_i,
    input  logic                  icache_req_i,
    input  logic                  icache_kill_i,
    input  logic [ADDR_WIDTH-1:0] icache_addr_i,
    output logic [LINE_WIDTH-1:0] icache_data_o,
    output logic                  icache_ack_o,
    output logic                  wmem_req_o,
    output logic [ADDR_WIDTH-1:0] wmem_addr_o,
    input  logic [WORD_WIDTH-1:0] wmem_rdata_i,
    input  logic                  wmem_rvalid_i
);

    localparam int BEATS  = LINE_WIDTH / WORD_WIDTH;
    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(WORD_WIDTH / 8);
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  ack_q, ack_d;

    // Next-state, beat/address sequencing and line assembly
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        line_d  = line_q;
        ack_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (icache_req_i && imem_sel_i && !icache_kill_i) begin
                    addr_d  = icache_addr_i & ~OFF_MASK;
                    beat_d  = '0;
                    state_d = S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (icache_kill_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wmem_rvalid_i) begin
                    if (icache_kill_i) begin
                        state_d = S_IDLE;
                    end else begin
                        line_d[int'(beat_q) * WORD_WIDTH +: WORD_WIDTH] = wmem_rdata_i;
                        if (beat_q == LAST_BEAT) begin
                            ack_d   = 1'b1;
                            state_d = S_ACK;
                        end else begin
                            // Aligned base keeps every beat inside the line; the add wraps naturally
                            beat_d  = beat_q + BEAT_W'(1);
                            addr_d  = addr_q + WORD_BYTES;
                            state_d = S_READ;
                        end
                    end
                end else if (icache_kill_i) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (wmem_rvalid_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            ack_q   <= ack_d;
        end
    end

    // Kill during READ must be able to cancel the strobe in that same cycle
    assign wmem_req_o    = (state_q == S_READ) && !icache_kill_i;
    assign wmem_addr_o   = addr_q;
    assign icache_ack_o  = ack_q;
    assign icache_data_o = line_q;

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder: a cycle-indexed expectation model
// plus a configurable-latency word memory that returns word = address.
module tb_imem_line_responder;

    logic         clk = 1'b0;
    logic         rst, sel, req, kill;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         ack, wreq;
    logic [31:0]  waddr, rdata;
    logic         rvalid;

    imem_line_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_sel_i    (sel),
        .icache_req_i  (req),
        .icache_kill_i (kill),
        .icache_addr_i (addr),
        .icache_data_o (data),
        .icache_ack_o  (ack),
        .wmem_req_o    (wreq),
        .wmem_addr_o   (waddr),
        .wmem_rdata_i  (rdata),
        .wmem_rvalid_i (rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           n_chk = 0;
    int           n_pass = 0;
    bit           chk_en = 1'b0;
    int           mem_lat = 1;
    int           pend_cnt = 0;
    logic [31:0]  pend_data;
    int           ack_cnt = 0;
    int           last_ack_cyc = -1;
    logic [31:0]  strobe_q[$];
    logic [31:0]  exp_addr[int];
    logic [127:0] exp_ack[int];

    localparam logic [127:0] LINE_1234 = 128'h0000123C_00001238_00001234_00001230;
    localparam logic [127:0] LINE_2000 = 128'h0000200C_00002008_00002004_00002000;
    localparam logic [127:0] LINE_6000 = 128'h0000600C_00006008_00006004_00006000;
    localparam logic [127:0] LINE_0200 = 128'h0000020C_00000208_00000204_00000200;
    localparam logic [127:0] LINE_9000 = 128'h0000900C_00009008_00009004_00009000;
    logic [31:0] lit34 [4] = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Accepted at edge t with memory latency lat: beat k strobes in cycle
    // t + k*(lat+1); the ack cycle follows the last return.
    task automatic model_line(input int t, input logic [31:0] a, input int lat,
                              input int nstr, input bit with_ack);
        logic [31:0]  base;
        logic [127:0] line;
        logic [31:0]  w;
        base = a & ~32'hF;
        line = '0;
        for (int k = 0; k < 4; k++) begin
            w = base + 32'(4 * k);
            line[k*32 +: 32] = w;
            if (k < nstr) exp_addr[t + k * (lat + 1)] = w;
        end
        if (with_ack) exp_ack[t + 4 * (lat + 1)] = line;
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic full_line(input logic [31:0] a, input int lat, output int t);
        mem_lat = lat;
        addr    = a;
        req     = 1'b1;
        t       = cyc + 1;
        model_line(t, a, lat, 4, 1'b1);
        to_cyc(t + 4 * (lat + 1));
        #3;
        req = 1'b0;
        to_cyc(t + 4 * (lat + 1) + 1);
    endtask

    // Per-cycle compare against the expectation tables
    initial begin
        bit er, ea;
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                er = exp_addr.exists(cyc);
                ea = exp_ack.exists(cyc);
                chk("wmem_req", 128'(wreq), 128'(er));
                if (er && wreq === 1'b1) chk("wmem_addr", 128'(waddr), 128'(exp_addr[cyc]));
                chk("icache_ack", 128'(ack), 128'(ea));
                if (ea && ack === 1'b1) chk("line_data", data, exp_ack[cyc]);
            end
            if (wreq === 1'b1) strobe_q.push_back(waddr);
            if (ack === 1'b1) begin
                ack_cnt++;
                last_ack_cyc = cyc;
            end
        end
    end

    // Word memory: one return per strobe, mem_lat cycles later
    initial begin
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            #2;
            rvalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = pend_data;
                end
            end
            if (wreq === 1'b1) begin
                chk("one_outstanding", 128'(pend_cnt), 128'd0);
                pend_cnt  = mem_lat;
                pend_data = waddr;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int t, a0;
        rst = 1'b1; sel = 1'b1; req = 1'b0; kill = 1'b0; addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_data", data, 128'd0);
        chk("rst_ack", 128'(ack), 128'd0);
        chk("rst_wreq", 128'(wreq), 128'd0);
        chk("rst_waddr", 128'(waddr), 128'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1-cycle memory, unaligned request address
        strobe_q.delete();
        full_line(32'h0000_1234, 1, t);
        chk("lat_mem1", 128'(last_ack_cyc + 1 - t), 128'd9);
        chk("data_1234", data, LINE_1234);
        chk("strobe_cnt", 128'(strobe_q.size()), 128'd4);
        for (int k = 0; k < 4; k++) chk("strobe_addr", 128'(strobe_q[k]), 128'(lit34[k]));

        // 3-cycle memory
        full_line(32'h0000_1234, 3, t);
        chk("lat_mem3", 128'(last_ack_cyc + 1 - t), 128'd17);
        chk("data_1234_l3", data, LINE_1234);

        // Kill in WAIT before data: drain absorbs the late return
        a0 = ack_cnt;
        mem_lat = 3; addr = 32'h3000; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h3000, 3, 2, 1'b0);
        to_cyc(t + 5); kill = 1'b1; req = 1'b0;
        to_cyc(t + 6); kill = 1'b0;
        to_cyc(t + 9);
        chk("drain_no_ack", 128'(ack_cnt), 128'(a0));
        full_line(32'h2000, 1, t);
        chk("data_2000", data, LINE_2000);

        // Kill coincident with returning data, then kill in READ
        a0 = ack_cnt;
        mem_lat = 1; addr = 32'h4000; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h4000, 1, 2, 1'b0);
        to_cyc(t + 3); kill = 1'b1; req = 1'b0;
        to_cyc(t + 4); kill = 1'b0;
        to_cyc(t + 6);
        addr = 32'h5000; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h5000, 1, 1, 1'b0);
        to_cyc(t + 2); kill = 1'b1; req = 1'b0;
        to_cyc(t + 3); kill = 1'b0;
        to_cyc(t + 5);
        chk("kill_no_ack", 128'(ack_cnt), 128'(a0));

        // Kill during ACK is ignored
        addr = 32'h6000; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h6000, 1, 4, 1'b1);
        to_cyc(t + 8); kill = 1'b1; req = 1'b0;
        to_cyc(t + 9); kill = 1'b0;
        to_cyc(t + 10);
        chk("ack_kill_data", data, LINE_6000);

        // Back-to-back with request held through the first ack
        a0 = ack_cnt;
        strobe_q.delete();
        addr = 32'h100; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h100, 1, 4, 1'b1);
        model_line(t + 10, 32'h200, 1, 4, 1'b1);
        to_cyc(t + 8); #3; addr = 32'h200;
        to_cyc(t + 18); #3; req = 1'b0;
        to_cyc(t + 19);
        chk("b2b_acks", 128'(ack_cnt - a0), 128'd2);
        chk("b2b_strobes", 128'(strobe_q.size()), 128'd8);
        chk("b2b_data", data, LINE_0200);

        // Deselected: request is ignored until sel rises; sel drop mid-flight is harmless
        a0 = ack_cnt;
        strobe_q.delete();
        sel = 1'b0; addr = 32'h7000; req = 1'b1;
        repeat (10) @(negedge clk);
        chk("nosel_strobes", 128'(strobe_q.size()), 128'd0);
        chk("nosel_acks", 128'(ack_cnt), 128'(a0));
        sel = 1'b1; t = cyc + 1;
        model_line(t, 32'h7000, 1, 4, 1'b1);
        to_cyc(t + 3); sel = 1'b0;
        to_cyc(t + 8); #3; req = 1'b0;
        to_cyc(t + 9); sel = 1'b1;
        chk("sel_acks", 128'(ack_cnt - a0), 128'd1);

        // Reset during WAIT of beat 2; the stale return lands in IDLE
        a0 = ack_cnt;
        mem_lat = 3; addr = 32'h8000; req = 1'b1; t = cyc + 1;
        model_line(t, 32'h8000, 3, 3, 1'b0);
        to_cyc(t + 9); rst = 1'b1; req = 1'b0;
        to_cyc(t + 10);
        chk("mid_rst_data", data, 128'd0);
        chk("mid_rst_ack", 128'(ack), 128'd0);
        chk("mid_rst_wreq", 128'(wreq), 128'd0);
        chk("mid_rst_waddr", 128'(waddr), 128'd0);
        rst = 1'b0;
        to_cyc(t + 14);
        chk("rst_no_ack", 128'(ack_cnt), 128'(a0));
        full_line(32'h9000, 1, t);
        chk("data_9000", data, LINE_9000);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
